ifmap_row_packer: RTL and testbench

- Upstream feeder for the CNN accelerator's IFmap buffer.
- Accepts a raw pixel stream over a valid/ready handshake.
- Tags each pixel with start-of-row and end-of-row flag bits, then writes the tagged words into the IFmap buffer write port (IFmap_buffer_in / IFmap_buffer_write_enable / IFmap_buffer_full).
- Handles a run-time row length and row count, and never writes while the buffer reports full.

---
 rtl/ifmap_row_packer.sv | 205 ++++++++++++++++++++
 tb/tb_ifmap_row_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_row_packer.sv
// Tags a raw pixel stream with start/end-of-row flags and writes the words into the IFmap buffer.
// Optional zero padding around each row is built in when IFMAP_ZERO_PAD_EN is defined.
module ifmap_row_packer #(
  parameter int IFMAP_BUFFER_WIDTH = 8,
  parameter int LEN_WIDTH          = 8,
  parameter int ROWS_WIDTH         = 8,
  parameter int PAD_WIDTH          = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          row_len,
  input  logic [ROWS_WIDTH-1:0]         num_rows,
`ifdef IFMAP_ZERO_PAD_EN
  input  logic [PAD_WIDTH-1:0]          pad_len,
`endif
  input  logic [IFMAP_BUFFER_WIDTH-3:0] pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in,
  output logic                          IFmap_buffer_write_enable,
  input  logic                          IFmap_buffer_full,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t                          state_r, state_s;
  logic [LEN_WIDTH-1:0]            len_r, col_r;
  logic [ROWS_WIDTH-1:0]           rows_r, row_r;
  logic [IFMAP_BUFFER_WIDTH-1:0]   hold_word_r;
  logic                            hold_valid_r, last_taken_r;
  logic                            busy_r, done_r, error_r;
  logic                            we_s, room_s, ready_s, take_s, load_s;
  logic                            sor_s, eor_s, col_end_s, last_row_s, row_end_s;
  logic                            start_ok_s, start_bad_s;
  logic [IFMAP_BUFFER_WIDTH-3:0]   data_s;

  assign we_s        = hold_valid_r & ~IFmap_buffer_full;
  assign room_s      = (state_r == STREAM) & (~hold_valid_r | we_s) & ~last_taken_r;
  assign col_end_s   = (col_r == len_r - LEN_WIDTH'(1));
  assign last_row_s  = (row_r == rows_r - ROWS_WIDTH'(1));
  assign start_ok_s  = (state_r == IDLE) & start & (row_len != '0) & (num_rows != '0);
  assign start_bad_s = (state_r == IDLE) & start & ((row_len == '0) | (num_rows == '0));
  assign take_s      = ready_s & pix_valid;

`ifdef IFMAP_ZERO_PAD_EN
  typedef enum logic [1:0] {LEAD = 2'd0, PIX = 2'd1, TRAIL = 2'd2} phase_t;

  phase_t               phase_r;
  logic [PAD_WIDTH-1:0] pad_r, pad_cnt_r;
  logic                 gen_s, pad_end_s;

  assign ready_s   = room_s & (phase_r == PIX);
  assign gen_s     = room_s & (phase_r != PIX);
  assign load_s    = take_s | gen_s;
  assign pad_end_s = (pad_cnt_r == pad_r - PAD_WIDTH'(1));

  // Word tagging: flags move onto the pad words whenever padding is enabled.
  always_comb begin
    data_s    = '0;
    sor_s     = 1'b0;
    eor_s     = 1'b0;
    row_end_s = 1'b0;
    case (phase_r)
      LEAD: begin
        sor_s = (pad_cnt_r == '0);
      end
      PIX: begin
        data_s    = pix_in;
        sor_s     = (col_r == '0) & (pad_r == '0);
        eor_s     = col_end_s & (pad_r == '0);
        row_end_s = take_s & col_end_s & (pad_r == '0);
      end
      TRAIL: begin
        eor_s     = pad_end_s;
        row_end_s = gen_s & pad_end_s;
      end
      default: begin
        data_s = '0;
      end
    endcase
  end

  // Pad phase sequencing: leading pads, pixels, trailing pads, per row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r   <= PIX;
      pad_r     <= '0;
      pad_cnt_r <= '0;
    end else if (start_ok_s) begin
      phase_r   <= (pad_len != '0) ? LEAD : PIX;
      pad_r     <= pad_len;
      pad_cnt_r <= '0;
    end else if (gen_s) begin
      if (pad_end_s) begin
        pad_cnt_r <= '0;
        phase_r   <= (phase_r == LEAD) ? PIX : LEAD;
      end else begin
        pad_cnt_r <= pad_cnt_r + PAD_WIDTH'(1);
      end
    end else if (take_s & col_end_s & (pad_r != '0)) begin
      phase_r <= TRAIL;
    end
  end
`else
  assign ready_s = room_s;
  assign load_s  = take_s;

  // Word tagging for the plain pixel stream.
  always_comb begin
    data_s    = pix_in;
    sor_s     = (col_r == '0);
    eor_s     = col_end_s;
    row_end_s = take_s & col_end_s;
  end
`endif

  // Column/row counters compare before incrementing so full-scale lengths never overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r        <= '0;
      rows_r       <= '0;
      col_r        <= '0;
      row_r        <= '0;
      last_taken_r <= 1'b0;
    end else if (start_ok_s) begin
      len_r        <= row_len;
      rows_r       <= num_rows;
      col_r        <= '0;
      row_r        <= '0;
      last_taken_r <= 1'b0;
    end else begin
      if (take_s) begin
        col_r <= col_end_s ? '0 : col_r + LEN_WIDTH'(1);
      end
      if (row_end_s) begin
        if (last_row_s) begin
          last_taken_r <= 1'b1;
        end else begin
          row_r <= row_r + ROWS_WIDTH'(1);
        end
      end
    end
  end

  // Single-entry hold register; a word stays put until the buffer accepts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_word_r  <= '0;
      hold_valid_r <= 1'b0;
    end else if (load_s) begin
      hold_word_r  <= {sor_s, eor_s, data_s};
      hold_valid_r <= 1'b1;
    end else if (we_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = STREAM;
        else            state_s = IDLE;
      end
      STREAM: begin
        if (last_taken_r & we_s) state_s = DONE;
        else                     state_s = STREAM;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered status strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == STREAM);
      done_r  <= (state_s == DONE);
      error_r <= start_bad_s;
    end
  end

  assign pix_ready                 = ready_s;
  assign IFmap_buffer_in           = hold_word_r;
  assign IFmap_buffer_write_enable = we_s;
  assign busy                      = busy_r;
  assign done                      = done_r;
  assign error                     = error_r;

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Directed bench for ifmap_row_packer: frame tables plus hand-written corner sequences.
module tb_ifmap_row_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] row_len, num_rows;
  logic [5:0] pix_in;
  logic       pix_valid, pix_ready;
  logic [7:0] buf_in;
  logic       we, full, busy, done, error;
`ifdef IFMAP_ZERO_PAD_EN
  logic [3:0] pad_len;
`endif

  ifmap_row_packer dut (
    .clk(clk), .reset(reset), .start(start), .row_len(row_len), .num_rows(num_rows),
`ifdef IFMAP_ZERO_PAD_EN
    .pad_len(pad_len),
`endif
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .IFmap_buffer_in(buf_in), .IFmap_buffer_write_enable(we),
    .IFmap_buffer_full(full), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] pix; logic [7:0] exp; } px_t;
  typedef struct { logic [7:0] len; logic [7:0] rows; int first; int n; } fr_t;
  px_t px[16];
  fr_t fr[3];

  int checks = 0, passes = 0;
  int cyc = 0;
  logic [7:0] wr_q[$];
  int wr_first = -1, wr_last = -1, done_cyc = -1, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wr_q.push_back(buf_in);
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_first = -1; wr_last = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] l, input logic [7:0] r);
    @(posedge clk); #1;
    start = 1'b1; row_len = l; num_rows = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs frame f; optional stall after stall_at accepted pixels, optional extra start at restart_at.
  task automatic run_frame(input int f, input int stall_at, input int stall_len, input int restart_at);
    int acc = 0, guard = 0, g = 0;
    bit stalled = 1'b0, released = 1'b0;
    clear_log();
    pulse_start(fr[f].len, fr[f].rows);
    chk("busy_on", {31'd0, busy}, 32'd1);
    while (acc < fr[f].n && guard < 300) begin
      start = 1'b0;
      if (acc == restart_at) begin
        start = 1'b1; row_len = 8'd1; num_rows = 8'd1;
      end
      pix_valid = 1'b1;
      pix_in = px[fr[f].first + acc].pix;
      if (acc == stall_at && !stalled) begin
        stalled = 1'b1;
        full = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_we", {31'd0, we}, 32'd0);
          chk("stall_word", {24'd0, buf_in}, {24'd0, px[fr[f].first + acc - 1].exp});
          chk("stall_ready", {31'd0, pix_ready}, 32'd0);
          @(posedge clk); #1;
        end
        full = 1'b0;
        released = 1'b1;
      end
      @(negedge clk);
      if (released) begin
        chk("release_we", {31'd0, we}, 32'd1);
        chk("release_ready", {31'd0, pix_ready}, 32'd1);
        released = 1'b0;
      end
      if (pix_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    chk("all_pixels_taken", acc, fr[f].n);
    while (done_cnt == 0 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    chk("done_seen", {31'd0, (done_cnt > 0)}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("done_after_last_write", done_cyc, wr_last + 1);
    chk("write_count", wr_q.size(), fr[f].n);
    for (int i = 0; i < fr[f].n && i < wr_q.size(); i++)
      chk($sformatf("word[%0d]", i), {24'd0, wr_q[i]}, {24'd0, px[fr[f].first + i].exp});
    if (stall_at < 0)
      chk("back_to_back", wr_last - wr_first, fr[f].n - 1);
    repeat (3) @(negedge clk);
    chk("single_done", done_cnt, 1);
    chk("done_low", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k, guard;
    px[0] = '{6'd1, 8'h81};   px[1] = '{6'd2, 8'h02};   px[2] = '{6'd3, 8'h43};
    px[3] = '{6'd4, 8'h84};   px[4] = '{6'd5, 8'h05};   px[5] = '{6'd6, 8'h46};
    px[6] = '{6'h3F, 8'hFF};  px[7] = '{6'h00, 8'hC0};  px[8] = '{6'h15, 8'hD5};
    px[9] = '{6'h3F, 8'hBF};  px[10] = '{6'h2A, 8'h6A}; px[11] = '{6'h00, 8'h80};
    px[12] = '{6'h01, 8'h41};
    fr[0] = '{8'd3, 8'd2, 0, 6};
    fr[1] = '{8'd1, 8'd3, 6, 3};
    fr[2] = '{8'd2, 8'd2, 9, 4};

    reset = 1'b0; start = 1'b0; row_len = 8'd0; num_rows = 8'd0;
    pix_in = 6'd0; pix_valid = 1'b0; full = 1'b0;
`ifdef IFMAP_ZERO_PAD_EN
    pad_len = 4'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_outputs", {27'd0, pix_ready, we, busy, done, error}, 32'd0);
    chk("rst_word", {24'd0, buf_in}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int f = 0; f < 3; f++) run_frame(f, -1, 0, -1);

    run_frame(0, 2, 4, -1);

    pulse_start(8'd0, 8'd2);
    @(negedge clk);
    chk("err_len0", {30'd0, error, busy}, 32'd2);
    @(negedge clk);
    chk("err_pulse_len", {31'd0, error}, 32'd0);
    pulse_start(8'd3, 8'd0);
    @(negedge clk);
    chk("err_rows0", {30'd0, error, busy}, 32'd2);
    @(negedge clk);
    chk("err_pulse_rows", {31'd0, error}, 32'd0);

    run_frame(0, -1, 0, 3);
    chk("no_err_on_busy_start", {31'd0, error}, 32'd0);

    clear_log();
    pulse_start(8'd3, 8'd2);
    pix_valid = 1'b1;
    k = 0; guard = 0;
    while (guard < 50) begin
      pix_in = px[k].pix;
      @(negedge clk); #1;
      if (wr_q.size() >= 2) break;
      if (pix_ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    reset = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("midrst_outputs", {27'd0, pix_ready, we, busy, done, error}, 32'd0);
    chk("midrst_word", {24'd0, buf_in}, 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(0, -1, 0, -1);

`ifdef IFMAP_ZERO_PAD_EN
    clear_log();
    pad_len = 4'd1;
    pulse_start(8'd2, 8'd1);
    pad_len = 4'd0;
    pix_valid = 1'b1;
    pix_in = 6'd7;
    k = 0; guard = 0;
    @(negedge clk);
    chk("pad_ready_lead", {31'd0, pix_ready}, 32'd0);
    while (k < 2 && guard < 20) begin
      @(posedge clk); #1;
      pix_in = (k == 0) ? 6'd7 : 6'd9;
      @(negedge clk);
      if (pix_ready) k++;
      guard++;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("pad_ready_trail", {31'd0, pix_ready}, 32'd0);
    guard = 0;
    while (done_cnt == 0 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("pad_count", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("pad_w0", {24'd0, wr_q[0]}, 32'h80);
      chk("pad_w1", {24'd0, wr_q[1]}, 32'h07);
      chk("pad_w2", {24'd0, wr_q[2]}, 32'h09);
      chk("pad_w3", {24'd0, wr_q[3]}, 32'h40);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
